btn_press_decoder: RTL



---
 rtl/btn_press_decoder_if.sv | 15 +
 rtl/btn_press_decoder.sv | 86 ++++++++
 2 files changed

// File: rtl/btn_press_decoder_if.sv
// btn_press_decoder_if: debounced button inputs and gesture outputs of btn_press_decoder
interface btn_press_decoder_if;
  logic       db_level;
  logic       db_tick;
  logic       short_tick;
  logic       long_tick;
  logic       double_tick;
  logic       repeat_tick;
  logic       held;
  logic [7:0] press_count;
  modport master (output db_level, db_tick,
                  input  short_tick, long_tick, double_tick, repeat_tick, held, press_count);
  modport slave  (input  db_level, db_tick,
                  output short_tick, long_tick, double_tick, repeat_tick, held, press_count);
endinterface

// File: rtl/btn_press_decoder.sv
// btn_press_decoder: turns debounced button level/tick into short, long and double-click pulses
// plus a press counter; define BTN_REPEAT_EN to add auto-repeat pulses while long-held.
module btn_press_decoder #(
  parameter int LONG_CYC   = 50_000_000,
  parameter int DCLK_CYC   = 25_000_000,
  parameter int REPEAT_CYC = 10_000_000,
  parameter int CW         = 26
) (
  input logic                clk,
  input logic                reset,
  btn_press_decoder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PRESSED, LONG_HELD, GAP, SECOND} state_t;
  localparam logic [CW-1:0] LONG_END = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] DCLK_END = CW'(DCLK_CYC - 1);
  state_t        r_state, w_next;
  logic [CW-1:0] r_timer, w_timer;
  logic          w_short, w_long, w_double, w_repeat;
  logic          r_short, r_long, r_double, r_repeat, r_held;
  logic [7:0]    r_count;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
      r_repeat <= 1'b0;
      r_held   <= 1'b0;
      r_count  <= '0;
    end else begin
      r_state  <= w_next;
      r_timer  <= w_timer;
      r_short  <= w_short;
      r_long   <= w_long;
      r_double <= w_double;
      r_repeat <= w_repeat;
      r_held   <= r_state == LONG_HELD;
      r_count  <= r_count + {7'd0, bus.db_tick};
    end
  end
  // The timer only advances in PRESSED and GAP, and each leaves before passing its terminal value.
  always_comb begin
    w_next  = r_state;
    w_timer = r_timer;
    case (r_state)
      IDLE: if (bus.db_tick) begin
        w_next  = PRESSED;
        w_timer = '0;
      end
      PRESSED: if (!bus.db_level) begin
        w_next  = GAP;
        w_timer = '0;
      end else if (r_timer == LONG_END) begin
        w_next  = LONG_HELD;
        w_timer = '0;
      end else w_timer = r_timer + 1'b1;
      LONG_HELD: w_next = bus.db_level ? LONG_HELD : IDLE;
      GAP: if (bus.db_tick) w_next = SECOND;
      else if (r_timer == DCLK_END) w_next = IDLE;
      else w_timer = r_timer + 1'b1;
      SECOND: w_next = bus.db_level ? SECOND : IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    w_long   = r_state == PRESSED && bus.db_level && r_timer == LONG_END;
    w_double = r_state == GAP && bus.db_tick;
    w_short  = r_state == GAP && !bus.db_tick && r_timer == DCLK_END;
  end
`ifdef BTN_REPEAT_EN
  localparam logic [CW-1:0] REP_END = CW'(REPEAT_CYC - 1);
  logic [CW-1:0] r_rep;
  assign w_repeat = r_state == LONG_HELD && bus.db_level && r_rep == REP_END;
  always_ff @(posedge clk)
    r_rep <= (reset || r_state != LONG_HELD || !bus.db_level || w_repeat) ? '0 : r_rep + 1'b1;
`else
  assign w_repeat = 1'b0;
`endif
  assign bus.short_tick  = r_short;
  assign bus.long_tick   = r_long;
  assign bus.double_tick = r_double;
  assign bus.repeat_tick = r_repeat;
  assign bus.held        = r_held;
  assign bus.press_count = r_count;
endmodule
